// File: rtl/vec_insn_pkg.sv
// ============================================================================
// vec_insn_pkg : RVV instruction class, opcode constants and decoded fields
// Rev 1.0
// ============================================================================
`default_nettype none

package vec_insn_pkg;

   typedef enum logic [1:0] {
      CLS_ALU     = 2'd0,
      CLS_CFG     = 2'd1,
      CLS_MEM     = 2'd2,
      CLS_ILLEGAL = 2'd3
   } insn_class_e;

   localparam logic [6:0] OPC_OP_V     = 7'h57;
   localparam logic [6:0] OPC_LOAD_FP  = 7'h07;
   localparam logic [6:0] OPC_STORE_FP = 7'h27;
   localparam logic [2:0] F3_OPCFG     = 3'b111;

   typedef struct packed {
      insn_class_e cls;
      logic [6:0]  opcode;
      logic [4:0]  dest;
      logic [4:0]  src_1;
      logic [4:0]  src_2;
      logic [2:0]  funct3;
      logic        vm;
      logic [5:0]  funct6;
      logic [1:0]  mop;
      logic        mew;
      logic [2:0]  nf;
      logic [10:0] zimm_11;
      logic [9:0]  zimm_10;
   } dec_fields_t;

   function automatic insn_class_e classify(input logic [31:0] insn);
      insn_class_e cls;
      cls = CLS_ILLEGAL;
      if (insn[6:0] == OPC_OP_V)
         cls = (insn[14:12] == F3_OPCFG) ? CLS_CFG : CLS_ALU;
      else if ((insn[6:0] == OPC_LOAD_FP) || (insn[6:0] == OPC_STORE_FP))
         cls = CLS_MEM;
      return cls;
   endfunction

   // Every field is extracted regardless of class; consumers pick what applies.
   function automatic dec_fields_t decode(input logic [31:0] insn);
      dec_fields_t f;
      f.cls     = classify(insn);
      f.opcode  = insn[6:0];
      f.dest    = insn[11:7];
      f.src_1   = insn[19:15];
      f.src_2   = insn[24:20];
      f.funct3  = insn[14:12];
      f.vm      = insn[25];
      f.funct6  = insn[31:26];
      f.mop     = insn[27:26];
      f.mew     = insn[28];
      f.nf      = insn[31:29];
      f.zimm_11 = insn[30:20];
      f.zimm_10 = insn[29:20];
      return f;
   endfunction

endpackage

`default_nettype wire

// File: rtl/insn_fifo.sv
// ============================================================================
// insn_fifo : count-based circular FIFO with synchronous flush
// Rev 1.0
// ============================================================================
`default_nettype none

module insn_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wdata_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o && !flush_i;
   assign do_pop  = pop_i && !empty_o && !flush_i;
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

`default_nettype wire

// File: rtl/vec_insn_queue_decoder.sv
// ============================================================================
// vec_insn_queue_decoder : buffered RVV decoder with registered output stage.
// Optional DECODE_ILLEGAL_PASS_EN forwards ILLEGAL entries instead of dropping.
// Rev 1.0
// ============================================================================
`default_nettype none

module vec_insn_queue_decoder
   import vec_insn_pkg::*;
#(
   parameter int INSN_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic [INSN_WIDTH-1:0]      in_insn,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [1:0]                 out_class,
   output logic [6:0]                 out_opcode,
   output logic [4:0]                 out_dest,
   output logic [4:0]                 out_src_1,
   output logic [4:0]                 out_src_2,
   output logic [2:0]                 out_funct3,
   output logic                       out_vm,
   output logic [5:0]                 out_funct6,
   output logic [1:0]                 out_mop,
   output logic                       out_mew,
   output logic [2:0]                 out_nf,
   output logic [10:0]                out_zimm_11,
   output logic [9:0]                 out_zimm_10,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   logic [INSN_WIDTH-1:0] head;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  load;
   logic                  drop;
   logic                  pop;
   dec_fields_t           head_fields;
   dec_fields_t           out_q;
   logic                  out_valid_q;

   insn_fifo #(
      .WIDTH (INSN_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (flush),
      .push_i  (in_valid),
      .wdata_i (in_insn),
      .pop_i   (pop),
      .rdata_o (head),
      .count_o (count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign in_ready    = !fifo_full;
   assign head_fields = decode(head);

`ifdef DECODE_ILLEGAL_PASS_EN
   assign drop = 1'b0;
`else
   // An ILLEGAL head is discarded without touching the output stage.
   assign drop = !fifo_empty && (head_fields.cls == CLS_ILLEGAL);
`endif

   assign load = !fifo_empty && !drop && (!out_valid_q || out_ready);
   assign pop  = load || drop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
      end else if (load) begin
         out_valid_q <= 1'b1;
         out_q       <= head_fields;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_class   = out_q.cls;
   assign out_opcode  = out_q.opcode;
   assign out_dest    = out_q.dest;
   assign out_src_1   = out_q.src_1;
   assign out_src_2   = out_q.src_2;
   assign out_funct3  = out_q.funct3;
   assign out_vm      = out_q.vm;
   assign out_funct6  = out_q.funct6;
   assign out_mop     = out_q.mop;
   assign out_mew     = out_q.mew;
   assign out_nf      = out_q.nf;
   assign out_zimm_11 = out_q.zimm_11;
   assign out_zimm_10 = out_q.zimm_10;

endmodule

`default_nettype wire

// File: tb/tb_vec_insn_queue_decoder.sv
// Scoreboarded bench for vec_insn_queue_decoder: expected instructions queue on
// accepted pushes and are compared field by field on each output handshake.
`default_nettype none
`timescale 1ns/1ps

module tb_vec_insn_queue_decoder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] in_insn = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [1:0]  out_class;
   logic [6:0]  out_opcode;
   logic [4:0]  out_dest, out_src_1, out_src_2;
   logic [2:0]  out_funct3;
   logic        out_vm;
   logic [5:0]  out_funct6;
   logic [1:0]  out_mop;
   logic        out_mew;
   logic [2:0]  out_nf;
   logic [10:0] out_zimm_11;
   logic [9:0]  out_zimm_10;
   logic [2:0]  count;

   int          checks = 0;
   int          errors = 0;
   int          pops = 0;
   logic [31:0] sb[$];

   vec_insn_queue_decoder #(.INSN_WIDTH(32), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_insn(in_insn), .in_valid(in_valid),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_class(out_class), .out_opcode(out_opcode), .out_dest(out_dest),
      .out_src_1(out_src_1), .out_src_2(out_src_2), .out_funct3(out_funct3),
      .out_vm(out_vm), .out_funct6(out_funct6), .out_mop(out_mop), .out_mew(out_mew),
      .out_nf(out_nf), .out_zimm_11(out_zimm_11), .out_zimm_10(out_zimm_10),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] model_class(input logic [31:0] i);
      case (i[6:0])
         7'h57:        return (i[14:12] == 3'b111) ? 2'd1 : 2'd0;
         7'h07, 7'h27: return 2'd2;
         default:      return 2'd3;
      endcase
   endfunction

   function automatic logic [58:0] model_fields(input logic [31:0] i);
      return {i[6:0], i[11:7], i[19:15], i[24:20], i[14:12], i[25], i[31:26],
              i[27:26], i[28], i[31:29], i[30:20], i[29:20]};
   endfunction

   function automatic logic [31:0] rand_legal();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 3))
         0:       r[6:0] = 7'h57;
         1:       r[6:0] = 7'h07;
         2:       r[6:0] = 7'h27;
         default: begin r[6:0] = 7'h57; r[14:12] = 3'b111; end
      endcase
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
               logic [31:0] e;
               e = sb.pop_front();
               pops++;
               check("out_class", 64'(out_class), 64'(model_class(e)));
               check("out_fields", 64'({out_opcode, out_dest, out_src_1, out_src_2,
                     out_funct3, out_vm, out_funct6, out_mop, out_mew, out_nf,
                     out_zimm_11, out_zimm_10}), 64'(model_fields(e)));
            end
         end
`ifndef DECODE_ILLEGAL_PASS_EN
         if (out_valid) check("class_never_3", 64'(out_class == 2'd3), 64'd0);
`endif
         if (flush) begin
            sb.delete();
         end else if (in_valid && in_ready) begin
`ifdef DECODE_ILLEGAL_PASS_EN
            sb.push_back(in_insn);
`else
            if (model_class(in_insn) != 2'd3) sb.push_back(in_insn);
`endif
         end
      end
   end

   task automatic push(input logic [31:0] insn);
      in_valid = 1'b1;
      in_insn  = insn;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] held;
      int          p0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_fields", 64'({out_class, out_dest, out_src_1, out_funct6}), 64'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // vadd.vv, two-edge latency
      out_ready = 1'b1;
      @(posedge clk);
      #1 push(32'h022180D7);
      @(negedge clk);
      check("lat_valid_n", 64'(out_valid), 64'd0);
      check("lat_count_n", 64'(count), 64'd1);
      @(negedge clk);
      check("vadd_valid", 64'(out_valid), 64'd1);
      check("vadd_fields", 64'({out_class, out_dest, out_src_1, out_src_2, out_vm, out_funct6}),
            64'({2'd0, 5'd1, 5'd3, 5'd2, 1'b1, 6'd0}));
      check("vadd_count", 64'(count), 64'd0);

      // vle32.v
      @(posedge clk);
      #1 push(32'h0202E207);
      @(negedge clk);
      @(negedge clk);
      check("vle_fields", 64'({out_class, out_funct3, out_src_1, out_dest, out_mop, out_nf}),
            64'({2'd2, 3'b110, 5'd5, 5'd4, 2'd0, 3'd0}));

      // back-to-back stream at full throughput
      for (int i = 0; i < 8; i++) push(rand_legal());
      repeat (4) @(negedge clk);

      // stall: 5 pushes with out_ready low
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(rand_legal());
      @(negedge clk);
      check("stall_count", 64'(count), 64'd4);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      held = {out_dest, out_src_1, out_src_2, out_funct6, out_class, out_funct3, 5'd0};
      in_valid = 1'b1;
      in_insn  = rand_legal();
      repeat (2) @(negedge clk);
      check("stall_count_hold", 64'(count), 64'd4);
      check("stall_out_hold", 64'({out_dest, out_src_1, out_src_2, out_funct6, out_class,
            out_funct3, 5'd0}), 64'(held));
      @(posedge clk);
      #1 in_valid = 1'b0;
      p0 = pops;
      out_ready = 1'b1;
      repeat (5) @(negedge clk);
      #1 check("drain_rate", 64'(pops - p0), 64'd5);
      @(negedge clk);
      check("drain_empty_valid", 64'(out_valid), 64'd0);
      check("drain_empty_count", 64'(count), 64'd0);

      // ILLEGAL opcode
      @(posedge clk);
      #1 push(32'h00000013);
      @(negedge clk);
      @(negedge clk);
`ifdef DECODE_ILLEGAL_PASS_EN
      check("illegal_valid", 64'(out_valid), 64'd1);
      check("illegal_class", 64'(out_class), 64'd3);
`else
      check("illegal_valid", 64'(out_valid), 64'd0);
      check("illegal_count", 64'(count), 64'd0);
`endif
      repeat (2) @(negedge clk);

      // flush with in_valid in the same cycle
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(rand_legal());
      @(negedge clk);
      check("preflush_count", 64'(count), 64'd3);
      check("preflush_valid", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;
      flush    = 1'b1;
      in_valid = 1'b1;
      in_insn  = 32'h0A5A5057;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("flush_count", 64'(count), 64'd0);
      check("flush_valid", 64'(out_valid), 64'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("postflush_valid", 64'(out_valid), 64'd0);
      end
      for (int i = 0; i < 3; i++) push(rand_legal());
      repeat (4) @(negedge clk);

      // asynchronous reset mid-stream
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) push(rand_legal());
      #2 rst = 1'b0;
      #1;
      sb.delete();
      check("arst_valid", 64'(out_valid), 64'd0);
      check("arst_count", 64'(count), 64'd0);
      check("arst_fields", 64'({out_class, out_opcode, out_dest, out_zimm_11}), 64'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("arst_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("arst_no_stale", 64'(out_valid), 64'd0);
      end

      push(32'h5E0030D7);
      repeat (3) @(negedge clk);
      check("sb_empty", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
